// File: rtl/regfile_storage_pkg.sv
// ----------------------------------------------------------------------------
// regfile_storage_pkg
// Shared constants for the architectural register file and its companions
// (read-port multiplexers, write decoder), plus the small leaf decoders the
// 5:32 write decoder is assembled from.
// ----------------------------------------------------------------------------
package regfile_storage_pkg;

    localparam int NUM_REGS         = 32;
    localparam int REG_ADDR_BITS    = 5;
    localparam int DEFAULT_ZERO_REG = 31;

    // 2:4 leaf decoder with enable; all-zero when disabled.
    function automatic logic [3:0] dec2_4(input logic en, input logic [1:0] sel);
        dec2_4 = en ? (4'b0001 << sel) : 4'b0000;
    endfunction

    // 3:8 leaf decoder, always enabled (gating happens in the 2:4 stage).
    function automatic logic [7:0] dec3_8(input logic [2:0] sel);
        dec3_8 = 8'b0000_0001 << sel;
    endfunction

endpackage

// File: rtl/decoder5_32.sv
// ----------------------------------------------------------------------------
// decoder5_32
// One-hot 5:32 decoder built from a 2:4 stage (sel[4:3], carries the enable)
// and a 3:8 stage (sel[2:0]); output bit 8*g+k = hi[g] & lo[k].
// Ports:
//   en   in   1   global enable; out is all-zero when low
//   sel  in   5   index to decode
//   out  out  32  one-hot select (out[sel] = 1 when en)
// ----------------------------------------------------------------------------
module decoder5_32
    import regfile_storage_pkg::*;
(
    input  logic                     en,
    input  logic [REG_ADDR_BITS-1:0] sel,
    output logic [NUM_REGS-1:0]      out
);

    logic [3:0] hi;
    logic [7:0] lo;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch can never be inferred.
        out = '0;
        hi  = dec2_4(en, sel[4:3]);
        lo  = dec3_8(sel[2:0]);
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < 8; k++) begin
                out[g*8 + k] = hi[g] & lo[k];
            end
        end
    end

endmodule

// File: rtl/regfile_storage.sv
// ----------------------------------------------------------------------------
// regfile_storage
// Architectural register storage: 32 x WIDTH registers, one synchronous write
// port, all registers exposed in parallel for the downstream read muxes.
// Register ZERO_REG is hardwired to zero and has no storage.
// Ports:
//   clk      in   1             write clock (rising edge)
//   reset    in   1             async active-high clear of every register
//   wr_en    in   1             write enable
//   wr_addr  in   5             destination register index
//   wr_data  in   WIDTH         data to write
//   regs     out  32 x WIDTH    regs[i] is register i, straight from flops
// ----------------------------------------------------------------------------
module regfile_storage
    import regfile_storage_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = DEFAULT_ZERO_REG
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             wr_en,
    input  logic [REG_ADDR_BITS-1:0]         wr_addr,
    input  logic [WIDTH-1:0]                 wr_data,
    output logic [NUM_REGS-1:0][WIDTH-1:0]   regs
);

    logic [NUM_REGS-1:0] reg_we;

    decoder5_32 u_wr_dec (
        .en  (wr_en),
        .sel (wr_addr),
        .out (reg_we)
    );

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (i == ZERO_REG) begin : g_zero
            // Writes to the zero register decode normally and are dropped here.
            logic unused_zero_we;
            assign unused_zero_we = reg_we[i];
            assign regs[i]        = '0;
        end else begin : g_store
            logic [WIDTH-1:0] reg_q;
            logic [WIDTH-1:0] reg_d;

            // Enable is a hold/load feedback mux in front of the flop; the
            // clock itself is never gated.
            assign reg_d = reg_we[i] ? wr_data : reg_q;

            // NOTE: every register is a discrete flop with its own async clear,
            // so the whole file reads zero during reset (this is not a RAM).
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    // NOTE: sequential state is always updated with <= so all
                    // flops sample pre-edge values regardless of block order.
                    reg_q <= '0;
                end else begin
                    reg_q <= reg_d;
                end
            end

            assign regs[i] = reg_q;
        end
    end

endmodule
